// File: rtl/fft_sample_bridge_if.sv
// Interface bundle for fft_sample_bridge: frame control, input stream,
// sample RAM port and output stream. The bridge uses the slave view; the
// surrounding system (core wrapper or testbench) uses the master view.
interface fft_sample_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    // Frame control
    logic                    i_start;
    logic [ADDR_WIDTH:0]     i_samples_number;
    logic                    o_data_loaded;
    logic                    i_calc_end;
    logic                    o_busy;
    logic                    o_len_err;

    // Input sample stream
    logic                    i_s_valid;
    logic [DATA_WIDTH-1:0]   i_s_data;
    logic                    i_s_last;
    logic                    o_s_ready;

    // Sample RAM port
    logic [ADDR_WIDTH-1:0]   o_ram_addr;
    logic [DATA_WIDTH-1:0]   o_ram_wdata;
    logic                    o_ram_we;
    logic                    o_ram_re;
    logic [DATA_WIDTH-1:0]   i_ram_rdata;

    // Output sample stream
    logic                    o_m_valid;
    logic [DATA_WIDTH-1:0]   o_m_data;
    logic                    o_m_last;
    logic                    i_m_ready;

    // Bridge side
    modport slave (
        input  i_start, i_samples_number, i_calc_end,
        input  i_s_valid, i_s_data, i_s_last,
        input  i_ram_rdata,
        input  i_m_ready,
        output o_data_loaded, o_busy, o_len_err,
        output o_s_ready,
        output o_ram_addr, o_ram_wdata, o_ram_we, o_ram_re,
        output o_m_valid, o_m_data, o_m_last
    );

    // System side
    modport master (
        output i_start, i_samples_number, i_calc_end,
        output i_s_valid, i_s_data, i_s_last,
        output i_ram_rdata,
        output i_m_ready,
        input  o_data_loaded, o_busy, o_len_err,
        input  o_s_ready,
        input  o_ram_addr, o_ram_wdata, o_ram_we, o_ram_re,
        input  o_m_valid, o_m_data, o_m_last
    );
endinterface

// File: rtl/fft_sample_bridge.sv
// fft_sample_bridge: loads an N-sample frame from a valid/ready stream into
// the FFT sample RAM, waits for the core, then drains N results from the RAM
// to a valid/ready output stream with full backpressure on both sides.
//
// Optional build macro FFT_BRIDGE_BITREV_EN: when defined, frames are always
// 2^ADDR_WIDTH samples long and sample k is written to bitreverse(k); the
// drain order stays natural.
//
// Drain path: reads are issued against a credit of RAM_RD_LATENCY+1 slots
// (reads in flight + entries held in the return FIFO). Returning data is
// presented straight to the output when the FIFO is empty, so a held-high
// i_m_ready sees the first sample RAM_RD_LATENCY cycles after the first read
// and one sample per cycle after that.
module fft_sample_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int RAM_RD_LATENCY = 1   // legal range 1..3
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    fft_sample_bridge_if.slave bus
);

    localparam int CNT_W      = ADDR_WIDTH + 1;
    localparam int DEPTH      = RAM_RD_LATENCY + 1;
    // Storage is sized for the largest legal latency; only DEPTH slots are used.
    localparam int FIFO_SLOTS = 4;
    localparam int OCC_W      = 3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(1) << ADDR_WIDTH;
    localparam logic [OCC_W-1:0] CREDITS = OCC_W'(DEPTH);
    localparam logic [1:0]       PTR_TOP = 2'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_CALC,
        DRAIN
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        n_reg;      // frame length latched at start
    logic [CNT_W-1:0]        wcnt;       // samples written during LOAD
    logic [CNT_W-1:0]        rcnt;       // reads issued during DRAIN
    logic [CNT_W-1:0]        ocnt;       // samples delivered during DRAIN
    logic                    s_ready_q;
    logic                    busy_q;

    // rd_pipe[i] marks a read issued i+1 cycles ago
    logic [RAM_RD_LATENCY-1:0] rd_pipe;
    logic [DATA_WIDTH-1:0]     fifo_mem [FIFO_SLOTS];
    logic [1:0]                wr_ptr;
    logic [1:0]                rd_ptr;
    logic [OCC_W-1:0]          fifo_cnt;
    logic [OCC_W-1:0]          outstanding;

    logic                    start_ok;
    logic [CNT_W-1:0]        start_n;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    wr_hs;
    logic                    wr_last;
    logic                    ret_valid;
    logic                    fifo_empty;
    logic                    m_valid;
    logic                    out_hs;
    logic                    out_last;
    logic                    rd_issue;
    logic                    fifo_push;
    logic                    fifo_pop;

    // Wrap a FIFO pointer at the last used slot rather than at a power of two.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == PTR_TOP) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef FFT_BRIDGE_BITREV_EN
    // Mirror the low ADDR_WIDTH bits of the sample index.
    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = v[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    // Fixed full-size frame: every start is accepted and the requested length is not used.
    logic unused_samples_number;
    assign unused_samples_number = ^bus.i_samples_number;
    assign start_n  = MAX_N;
    assign start_ok = bus.i_start;
    assign wr_addr  = bit_rev(wcnt[ADDR_WIDTH-1:0]);
`else
    assign start_n  = bus.i_samples_number;
    assign start_ok = bus.i_start && (start_n != '0) && (start_n <= MAX_N);
    assign wr_addr  = wcnt[ADDR_WIDTH-1:0];
`endif

    // Load side: s_ready_q is high exactly while in LOAD.
    assign wr_hs   = s_ready_q & bus.i_s_valid;
    assign wr_last = (wcnt == n_reg - CNT_ONE);

    // Drain side: a return is either bypassed to the output or queued.
    assign ret_valid  = rd_pipe[RAM_RD_LATENCY-1];
    assign fifo_empty = (fifo_cnt == '0);
    assign m_valid    = !fifo_empty || ret_valid;
    assign out_hs     = m_valid && bus.i_m_ready;
    assign out_last   = (ocnt == n_reg - CNT_ONE);
    assign fifo_push  = ret_valid && !(fifo_empty && bus.i_m_ready);
    assign fifo_pop   = out_hs && !fifo_empty;
    assign rd_issue   = (state == DRAIN) && (rcnt < n_reg) &&
                        ((outstanding + fifo_cnt) < CREDITS);

    // Count reads currently in flight towards the credit limit.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            outstanding = outstanding + OCC_W'(rd_pipe[i]);
        end
    end

    // Share the RAM address between writes and reads and select the output sample.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
        bus.o_ram_addr = '0;
        bus.o_m_data   = '0;
        if (wr_hs) begin
            bus.o_ram_addr = wr_addr;
        end else if (rd_issue) begin
            bus.o_ram_addr = rcnt[ADDR_WIDTH-1:0];
        end
        if (!fifo_empty) begin
            bus.o_m_data = fifo_mem[rd_ptr];
        end else if (ret_valid) begin
            bus.o_m_data = bus.i_ram_rdata;
        end
    end

    assign bus.o_ram_we      = wr_hs;
    assign bus.o_ram_wdata   = wr_hs ? bus.i_s_data : '0;
    assign bus.o_ram_re      = rd_issue;
    assign bus.o_data_loaded = wr_hs && wr_last;
    assign bus.o_len_err     = wr_hs && (bus.i_s_last != wr_last);
    assign bus.o_s_ready     = s_ready_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_m_valid     = m_valid;
    assign bus.o_m_last      = m_valid && out_last;

    // Frame sequencing: IDLE -> LOAD -> WAIT_CALC -> DRAIN -> IDLE, with counters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values regardless of statement order.
        if (!i_rstn) begin
            state     <= IDLE;
            n_reg     <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            ocnt      <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        n_reg     <= start_n;
                        wcnt      <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (wr_hs) begin
                        wcnt <= wcnt + CNT_ONE;
                        if (wr_last) begin
                            s_ready_q <= 1'b0;
                            state     <= WAIT_CALC;
                        end
                    end
                end
                WAIT_CALC: begin
                    if (bus.i_calc_end) begin
                        rcnt  <= '0;
                        ocnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_issue) begin
                        rcnt <= rcnt + CNT_ONE;
                    end
                    if (out_hs) begin
                        ocnt <= ocnt + CNT_ONE;
                        if (out_last) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Track reads in flight and the return FIFO's pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_pipe  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RAM_RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (fifo_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (fifo_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Capture returning read data that cannot be handed straight to the output.
    always_ff @(posedge i_clk) begin
        // NOTE: the payload array has no reset; fifo_cnt alone says which entries are valid, so stale contents are never observed.
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= bus.i_ram_rdata;
        end
    end

endmodule

// File: tb/tb_fft_sample_bridge.sv
// Self-checking bench for fft_sample_bridge (ADDR_WIDTH=4, RAM_RD_LATENCY=3).
// A behavioural RAM with the configured read latency sits on the RAM port.
// The reference keeps the expected RAM image as an array filled from the
// frame rules (sample k -> address k, or bitreverse(k) when
// FFT_BRIDGE_BITREV_EN is defined) and expects the drain to replay that
// image in address order.
module tb_fft_sample_bridge;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 3;
    localparam int N_MAX = 1 << AW;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_ram [N_MAX];
    logic [DW-1:0] ram     [N_MAX];
    logic          rd_v    [LAT];
    logic [AW-1:0] rd_a    [LAT];

    int issued;
    int accepted;

    fft_sample_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fft_sample_bridge #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .RAM_RD_LATENCY(LAT)
    ) dut (
        .i_clk (clk),
        .i_rstn(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sample RAM: writes on the edge, read data valid LAT cycles after o_ram_re.
    initial begin
        for (int i = 0; i < LAT; i++) begin
            rd_v[i] = 1'b0;
            rd_a[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
        rd_v[0] <= bus.o_ram_re;
        rd_a[0] <= bus.o_ram_addr;
        for (int i = 1; i < LAT; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_a[i] <= rd_a[i-1];
        end
    end
    assign bus.i_ram_rdata = rd_v[LAT-1] ? ram[rd_a[LAT-1]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int k);
`ifdef FFT_BRIDGE_BITREV_EN
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            if ((k >> b) % 2 == 1) r += 1 << (AW - 1 - b);
        end
        return r;
`else
        return k;
`endif
    endfunction

    function automatic int n_eff(input int n);
`ifdef FFT_BRIDGE_BITREV_EN
        return N_MAX;
`else
        return n;
`endif
    endfunction

    task automatic check_quiet(input string pfx);
        check({pfx, "_s_ready"}, bus.o_s_ready, 0);
        check({pfx, "_busy"}, bus.o_busy, 0);
        check({pfx, "_we"}, bus.o_ram_we, 0);
        check({pfx, "_re"}, bus.o_ram_re, 0);
        check({pfx, "_addr"}, bus.o_ram_addr, 0);
        check({pfx, "_wdata"}, bus.o_ram_wdata, 0);
        check({pfx, "_loaded"}, bus.o_data_loaded, 0);
        check({pfx, "_len_err"}, bus.o_len_err, 0);
        check({pfx, "_m_valid"}, bus.o_m_valid, 0);
        check({pfx, "_m_data"}, bus.o_m_data, 0);
        check({pfx, "_m_last"}, bus.o_m_last, 0);
    endtask

    // Invariants checked every cycle: exclusive RAM strobes and the read credit limit.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            issued   = 0;
            accepted = 0;
        end else begin
            check("we_re_excl", bus.o_ram_we & bus.o_ram_re, 0);
            if (bus.o_ram_re) begin
                check("credit", (issued + 1 - accepted) <= LAT + 1, 1);
                issued++;
            end
            if (bus.o_m_valid && bus.i_m_ready) accepted++;
        end
    end

    task automatic load_frame(input int n, input int last_pos, input bit rand_data,
                              input bit rand_valid, input bit calc_noise);
        int ne;
        int k;
        int guard;
        bit v;
        logic [DW-1:0] d;
        ne = n_eff(n);
        k = 0;
        guard = 0;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_samples_number = (AW+1)'(n);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_samples_number = (AW+1)'($urandom);  // must have been latched already
        #1;
        check("load_busy", bus.o_busy, 1);
        check("load_ready", bus.o_s_ready, 1);
        while (k < ne && guard < 400) begin
            v = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            d = rand_data ? DW'($urandom) : DW'(32'h100 + k);
            bus.i_s_valid  = v;
            bus.i_s_data   = d;
            bus.i_s_last   = (k == last_pos);
            bus.i_calc_end = calc_noise ? ($urandom_range(0, 1) == 1) : 1'b0;
            #1;
            if (v) begin
                check("wr_we", bus.o_ram_we, 1);
                check("wr_addr", bus.o_ram_addr, exp_addr(k));
                check("wr_data", bus.o_ram_wdata, d);
                check("wr_loaded", bus.o_data_loaded, k == ne - 1);
                check("wr_len_err", bus.o_len_err, (k == last_pos) != (k == ne - 1));
                exp_ram[exp_addr(k)] = d;
                k++;
            end else begin
                check("nowr_we", bus.o_ram_we, 0);
                check("nowr_loaded", bus.o_data_loaded, 0);
                check("nowr_len_err", bus.o_len_err, 0);
            end
            @(negedge clk);
            guard++;
        end
        check("load_count", k, ne);
        bus.i_s_valid  = 1'b0;
        bus.i_s_last   = 1'b0;
        bus.i_calc_end = 1'b0;
        #1;
        check("wait_ready", bus.o_s_ready, 0);
        check("wait_busy", bus.o_busy, 1);
        repeat (3) @(negedge clk);
        #1;
        check("wait_no_read", bus.o_ram_re, 0);
        check("wait_still_busy", bus.o_busy, 1);
    endtask

    task automatic drain_frame(input int n, input bit rand_ready, input int stop_after);
        int ne;
        int j;
        int c;
        int first_re;
        int first_v;
        bit r;
        bit prev_v;
        bit prev_r;
        bit prev_l;
        bit was_reset;
        logic [DW-1:0] prev_d;
        ne = n_eff(n);
        j = 0;
        c = 0;
        first_re = -1;
        first_v = -1;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_l = 1'b0;
        prev_d = '0;
        was_reset = 1'b0;
        @(negedge clk);
        bus.i_calc_end = 1'b1;
        @(negedge clk);
        bus.i_calc_end = 1'b0;
        while (j < ne && c < 400) begin
            if (stop_after > 0 && c == stop_after) begin
                rst_n = 1'b0;
                #1;
                check_quiet("rst_mid");
                was_reset = 1'b1;
                break;
            end
            r = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.i_m_ready = r;
            #1;
            if (bus.o_ram_re && first_re < 0) first_re = c;
            if (bus.o_m_valid) begin
                if (first_v < 0) first_v = c;
                if (prev_v && !prev_r) begin
                    check("hold_data", bus.o_m_data, prev_d);
                    check("hold_last", bus.o_m_last, prev_l);
                end
                if (r) begin
                    check("out_data", bus.o_m_data, exp_ram[j]);
                    check("out_last", bus.o_m_last, j == ne - 1);
                    j++;
                end
            end else begin
                if (prev_v && !prev_r) check("hold_valid", bus.o_m_valid, 1);
                if (!rand_ready && first_v >= 0) check("stream_gap", bus.o_m_valid, 1);
            end
            prev_v = bus.o_m_valid;
            prev_r = r;
            prev_d = bus.o_m_data;
            prev_l = bus.o_m_last;
            @(negedge clk);
            c++;
        end
        bus.i_m_ready = 1'b0;
        if (was_reset) begin
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            check("drain_count", j, ne);
            if (!rand_ready) begin
                check("first_read_cycle", first_re, 0);
                check("first_latency", first_v - first_re, LAT);
                check("drain_cycles", c, LAT + ne);
            end
            #1;
            check("end_busy", bus.o_busy, 0);
            check("end_m_valid", bus.o_m_valid, 0);
            check("end_s_ready", bus.o_s_ready, 0);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                = 1'b0;
        bus.i_start          = 1'b0;
        bus.i_samples_number = '0;
        bus.i_s_valid        = 1'b0;
        bus.i_s_data         = '0;
        bus.i_s_last         = 1'b0;
        bus.i_calc_end       = 1'b0;
        bus.i_m_ready        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // i_calc_end in IDLE must be ignored.
        @(negedge clk);
        bus.i_calc_end = 1'b1;
        @(negedge clk);
        bus.i_calc_end = 1'b0;
        #1;
        check("idle_calc_ignored", bus.o_busy, 0);

        // Frame 1: 0x100+k, valid held high, ready held high.
        load_frame(16, 15, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) check("ram_image", ram[exp_addr(k)], 32'h100 + k);
        drain_frame(16, 1'b0, 0);

        // Frame 2: random data, random valid, stray i_calc_end during LOAD, random ready.
        load_frame(16, 15, 1'b1, 1'b1, 1'b1);
        drain_frame(16, 1'b1, 0);

        // Frame 3: N=5 with i_s_last on the 3rd sample.
        load_frame(5, 2, 1'b1, 1'b0, 1'b0);
        drain_frame(5, 1'b1, 0);

`ifndef FFT_BRIDGE_BITREV_EN
        // Illegal lengths are ignored.
        foreach (exp_ram[i]) begin end
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus.i_start = 1'b1;
            bus.i_samples_number = (t == 0) ? (AW+1)'(0) : (AW+1)'(17);
            @(negedge clk);
            bus.i_start = 1'b0;
            #1;
            check("bad_len_busy", bus.o_busy, 0);
            check("bad_len_ready", bus.o_s_ready, 0);
        end
`endif

        // Frame 4: reset in the middle of DRAIN.
        load_frame(16, 15, 1'b1, 1'b1, 1'b0);
        drain_frame(16, 1'b0, 6);
        #1;
        check("after_rst_busy", bus.o_busy, 0);

        // Frame 5: normal operation after the reset.
        load_frame(7, 6, 1'b1, 1'b1, 1'b0);
        drain_frame(7, 1'b1, 0);

        // Frame 6: single-sample frame, full throughput.
        load_frame(1, 0, 1'b1, 1'b0, 1'b0);
        drain_frame(1, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_sample_bridge.md
Name: fft_sample_bridge

Overview:
Parametrised stream-to-RAM bridge for the FFT core. It loads a frame of N samples from an input valid/ready stream into the sample RAM and signals the core when the frame is loaded. After the core reports completion, it drains the N results from RAM to an output valid/ready stream. Unlike the previous bridge, it supports true backpressure on both sides, a configurable RAM read latency, a runtime frame length latched per frame, and frame-length error reporting.

Parameters:
DATA_WIDTH, 32, sample width in bits (input stream, output stream, RAM data)
ADDR_WIDTH, 12, RAM address width; maximum frame length is 2^ADDR_WIDTH
RAM_RD_LATENCY, 1, cycles from o_ram_re to i_ram_rdata valid; legal values 1..3

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  frame start pulse; sampled in IDLE only
i_samples_number  in  ADDR_WIDTH+1  frame length N; latched on accepted i_start
i_s_valid  in  1  input sample valid
i_s_data  in  DATA_WIDTH  input sample
i_s_last  in  1  input end-of-frame marker (checked, not used for length)
o_s_ready  out  1  input ready
o_ram_addr  out  ADDR_WIDTH  RAM address
o_ram_wdata  out  DATA_WIDTH  RAM write data
o_ram_we  out  1  RAM write strobe
o_ram_re  out  1  RAM read strobe
i_ram_rdata  in  DATA_WIDTH  RAM read data
o_data_loaded  out  1  one-cycle pulse: frame fully written
i_calc_end  in  1  FFT done; sampled in WAIT_CALC only
o_m_valid  out  1  output sample valid
o_m_data  out  DATA_WIDTH  output sample
o_m_last  out  1  high with the final output sample
i_m_ready  in  1  output ready
o_busy  out  1  high whenever state != IDLE
o_len_err  out  1  one-cycle pulse on i_s_last mismatch

Behaviour:
- Reset (async, any state): state=IDLE; counters=0; output buffer flushed; outstanding reads discarded; all outputs 0.
- States: IDLE, LOAD, WAIT_CALC, DRAIN.
- IDLE: o_s_ready=0, o_m_valid=0. On i_start with 0 < N <= 2^ADDR_WIDTH: latch N, wcnt=0, go LOAD. If N=0 or N>2^ADDR_WIDTH, i_start is ignored and the block stays IDLE.
- LOAD: o_s_ready=1. Each handshake (valid&ready) drives o_ram_we=1, o_ram_addr=wcnt, o_ram_wdata=i_s_data combinationally in the same cycle, then wcnt++.
  - On the handshake with wcnt==N-1: o_data_loaded=1 in that cycle; next state is WAIT_CALC.
  - o_len_err pulses if i_s_last=1 on a handshake with wcnt!=N-1, or i_s_last=0 on the handshake with wcnt==N-1. Data is still stored; length is always N.
- WAIT_CALC: o_s_ready=0, no RAM access. i_calc_end=1 moves to DRAIN with rcnt=0 and ocnt=0. i_calc_end in any other state is ignored (not latched).
- DRAIN:
  - Read issue: o_ram_re=1, o_ram_addr=rcnt when rcnt<N and (outstanding reads + buffer occupancy) < RAM_RD_LATENCY+1. rcnt++ per issue.
  - Read return: data returns RAM_RD_LATENCY cycles after issue into a FIFO of depth RAM_RD_LATENCY+1. The credit rule guarantees no overflow and no dropped data.
  - Output: o_m_valid = FIFO not empty; o_m_data = FIFO head. o_m_last=1 while the head is sample N-1 (ocnt==N-1).
  - Each output handshake pops the FIFO and increments ocnt. The handshake on the last sample returns to IDLE on the next edge.
  - Output data and valid are stable while i_m_ready=0.
  - Throughput is 1 sample/cycle with i_m_ready held high after the initial latency.
- Counters are ADDR_WIDTH+1 bits wide; N=2^ADDR_WIDTH is legal and addresses 0..2^ADDR_WIDTH-1 without wrap.
- o_ram_we and o_ram_re are never both high in the same cycle.

Optional Feature:
FFT_BRIDGE_BITREV_EN
- Defined: LOAD writes sample k to address bitreverse(k) over ADDR_WIDTH bits. i_samples_number is ignored and N is fixed at 2^ADDR_WIDTH. i_start is always accepted in IDLE. DRAIN order is unchanged (natural).
- Undefined: natural-order addressing as described in Behaviour.

Test Plan:
- ADDR_WIDTH=4, N=16, i_s_valid held high, 16 samples 0x100+k -> RAM[k]=0x100+k; o_data_loaded on the 16th handshake only; o_len_err never pulses when i_s_last is on k=15.
- i_calc_end=1 then i_m_ready=1 constantly, RAM_RD_LATENCY=2 -> first o_m_valid 2 cycles after first o_ram_re; 16 consecutive valid cycles; o_m_last only on 0x10F; return to IDLE.
- Random i_m_ready (~50%) with RAM_RD_LATENCY=3 -> output sequence identical to RAM contents, no drop or duplicate; outstanding reads + occupancy never exceed 4.
- N=5 with i_s_last on the 3rd sample -> o_len_err pulses at the 3rd handshake; 5 samples stored; o_data_loaded on the 5th.
- i_start with N=0 and with N=17 (ADDR_WIDTH=4) -> stays IDLE, o_busy=0. Then i_rstn low mid-DRAIN -> all outputs 0 immediately; the next frame runs normally.
- FFT_BRIDGE_BITREV_EN defined, ADDR_WIDTH=3, samples k=0..7 -> RAM addresses written in order 0,4,2,6,1,5,3,7.
